// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 decode definitions.
// Provides icode constants, register index type, the RNONE/RRSP specifiers
// and a helper that tells whether an index names a real register.
package y86_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t RNONE = 4'hF;
  localparam reg_idx_t RRSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovxx
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // True when idx addresses storage; RNONE and anything past the array
  // read as zero and never write.
  function automatic logic idx_valid(reg_idx_t idx, int nregs);
    return int'(idx) < nregs;
  endfunction

endpackage

// File: rtl/y86_src_select.sv
// y86_src_select: combinational source-register selection from icode.
// Ports:
//   i_icode  instruction code
//   i_rA     register specifier A
//   i_rB     register specifier B
//   o_srcA   source A index (RNONE when unused)
//   o_srcB   source B index (RNONE when unused)
// Also used by the pipeline hazard unit, so it stays purely combinational.
module y86_src_select
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  input  reg_idx_t   i_rA,
  input  reg_idx_t   i_rB,
  output reg_idx_t   o_srcA,
  output reg_idx_t   o_srcB
);

  always_comb begin
    o_srcA = RNONE;
    case (i_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: o_srcA = i_rA;
      I_RET, I_POPQ:                      o_srcA = RRSP;
      default:                            o_srcA = RNONE;
    endcase
  end

  always_comb begin
    o_srcB = RNONE;
    case (i_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          o_srcB = i_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     o_srcB = RRSP;
      default:                            o_srcB = RNONE;
    endcase
  end

endmodule

// File: rtl/y86_regfile_decode.sv
// y86_regfile_decode: Y86-64 register file plus decode output register.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, stall     input qualifier, output-register hold
//   icode, rA, rB       decode inputs
//   dstE/valE, dstM/valM write-back ports (RNONE = no write, M wins ties)
//   out_valid, srcA, srcB, valA, valB   registered decode results
// BYPASS=1 forwards same-cycle write data into the read ports.
module y86_regfile_decode
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                NREGS     = 15,
  parameter logic [DATA_W-1:0] RSP_RESET = '0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              out_valid,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB
);

  logic [DATA_W-1:0] r_regs [NREGS];

  reg_idx_t          w_srcA, w_srcB;
  logic              w_we_e, w_we_m;
  logic [DATA_W-1:0] w_valA, w_valB;

  logic              r_out_valid;
  reg_idx_t          r_srcA, r_srcB;
  logic [DATA_W-1:0] r_valA, r_valB;

  y86_src_select u_src (
    .i_icode (icode),
    .i_rA    (rA),
    .i_rB    (rB),
    .o_srcA  (w_srcA),
    .o_srcB  (w_srcB)
  );

  assign w_we_e = idx_valid(dstE, NREGS);
  assign w_we_m = idx_valid(dstM, NREGS);

  // Read ports: M forwarding beats E, matching the write precedence below.
  always_comb begin
    w_valA = '0;
    if (idx_valid(w_srcA, NREGS)) begin
      if (BYPASS && w_we_m && dstM == w_srcA)      w_valA = valM;
      else if (BYPASS && w_we_e && dstE == w_srcA) w_valA = valE;
      else                                         w_valA = r_regs[w_srcA];
    end
  end

  always_comb begin
    w_valB = '0;
    if (idx_valid(w_srcB, NREGS)) begin
      if (BYPASS && w_we_m && dstM == w_srcB)      w_valB = valM;
      else if (BYPASS && w_we_e && dstE == w_srcB) w_valB = valE;
      else                                         w_valB = r_regs[w_srcB];
    end
  end

  // Storage: M write issued last so it wins when dstE == dstM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= (i == int'(RRSP)) ? RSP_RESET : '0;
    end else begin
      if (w_we_e) r_regs[dstE] <= valE;
      if (w_we_m) r_regs[dstM] <= valM;
    end
  end

  // Output register: stall freezes everything including out_valid;
  // an idle cycle flushes to the bubble pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_srcA      <= RNONE;
      r_srcB      <= RNONE;
      r_valA      <= '0;
      r_valB      <= '0;
    end else if (!stall) begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_srcA <= w_srcA;
        r_srcB <= w_srcB;
        r_valA <= w_valA;
        r_valB <= w_valB;
      end else begin
        r_srcA <= RNONE;
        r_srcB <= RNONE;
        r_valA <= '0;
        r_valB <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign srcA      = r_srcA;
  assign srcB      = r_srcB;
  assign valA      = r_valA;
  assign valB      = r_valB;

endmodule

// File: tb/tb_y86_regfile_decode.sv
// Scoreboard bench: two DUTs (BYPASS=1 / BYPASS=0) share stimulus; a
// behavioural model predicts their outputs and a monitor compares them.
module tb_y86_regfile_decode;

  localparam int          DW   = 64;
  localparam int          NR   = 15;
  localparam logic [63:0] RSPV = 64'h200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, stall = 1'b0;
  logic [3:0]  icode = 4'h0, rA = 4'h0, rB = 4'h0, dstE = 4'hF, dstM = 4'hF;
  logic [63:0] valE = '0, valM = '0;

  logic        ov1, ov0;
  logic [3:0]  sa1, sb1, sa0, sb0;
  logic [63:0] va1, vb1, va0, vb0;

  always #5 clk = ~clk;

  y86_regfile_decode #(.DATA_W(DW), .NREGS(NR), .RSP_RESET(RSPV), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .icode(icode), .rA(rA), .rB(rB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .out_valid(ov1), .srcA(sa1), .srcB(sb1), .valA(va1), .valB(vb1));

  y86_regfile_decode #(.DATA_W(DW), .NREGS(NR), .RSP_RESET(RSPV), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .icode(icode), .rA(rA), .rB(rB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .out_valid(ov0), .srcA(sa0), .srcB(sb0), .valA(va0), .valB(vb0));

  typedef struct {
    logic        ov;
    logic [3:0]  sa, sb;
    logic [63:0] a1, b1, a0, b0;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [63:0] mdl [16];
  int          total = 0, bad = 0;
  bit          started = 0, done = 0;

  function automatic logic [3:0] m_srcA(logic [3:0] ic, logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(logic [3:0] ic, logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  // Value seen at decode for idx given this cycle's write-back ports.
  function automatic logic [63:0] m_read(logic [3:0] idx, bit byp,
                                         logic [3:0] de, logic [63:0] ve,
                                         logic [3:0] dm, logic [63:0] vm);
    if (int'(idx) >= NR) return 64'h0;
    if (byp && dm == idx) return vm;
    if (byp && de == idx) return ve;
    return mdl[idx];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 64'h0;
    mdl[4] = RSPV;
    cur = '{ov: 1'b0, sa: 4'hF, sb: 4'hF, a1: 64'h0, b1: 64'h0, a0: 64'h0, b0: 64'h0};
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit iv, bit st, logic [3:0] ic, logic [3:0] ra, logic [3:0] rb,
                      logic [3:0] de, logic [63:0] ve, logic [3:0] dm, logic [63:0] vm);
    @(negedge clk);
    rst_n = r; in_valid = iv; stall = st; icode = ic; rA = ra; rB = rb;
    dstE = de; valE = ve; dstM = dm; valM = vm;
    started = 1;
    if (!r) begin
      mdl_reset();
    end else begin
      if (!st) begin
        cur.ov = iv;
        if (iv) begin
          cur.sa = m_srcA(ic, ra);
          cur.sb = m_srcB(ic, rb);
          cur.a1 = m_read(cur.sa, 1'b1, de, ve, dm, vm);
          cur.b1 = m_read(cur.sb, 1'b1, de, ve, dm, vm);
          cur.a0 = m_read(cur.sa, 1'b0, de, ve, dm, vm);
          cur.b0 = m_read(cur.sb, 1'b0, de, ve, dm, vm);
        end else begin
          cur.sa = 4'hF; cur.sb = 4'hF;
          cur.a1 = 0; cur.b1 = 0; cur.a0 = 0; cur.b0 = 0;
        end
      end
      if (int'(de) < NR) mdl[de] = ve;
      if (int'(dm) < NR) mdl[dm] = vm;
    end
    q.push_back(cur);
  endtask

  // Monitor: one expected entry per clock edge once stimulus has begun.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("byp.out_valid", 64'(ov1), 64'(e.ov));
        chk("byp.srcA", 64'(sa1), 64'(e.sa));
        chk("byp.srcB", 64'(sb1), 64'(e.sb));
        chk("byp.valA", va1, e.a1);
        chk("byp.valB", vb1, e.b1);
        chk("nob.out_valid", 64'(ov0), 64'(e.ov));
        chk("nob.srcA", 64'(sa0), 64'(e.sa));
        chk("nob.srcB", 64'(sb0), 64'(e.sb));
        chk("nob.valA", va0, e.a0);
        chk("nob.valB", vb0, e.b0);
      end else if (started && !done) begin
        total++; bad++;
        $display("FAIL scoreboard_empty got=0 expected=1 @%0t", $time);
      end
    end
  end

  initial begin
    mdl_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset.out_valid", 64'(ov1), 64'h0);
    chk("reset.srcA", 64'(sa1), 64'hF);
    chk("reset.srcB", 64'(sb1), 64'hF);
    chk("reset.valA", va1, 64'h0);

    step(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);
    step(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);
    // ret reads %rsp on both ports
    step(1, 1, 0, 4'h9, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);
    // E and M to the same register: M wins
    step(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h3, 64'h11, 4'h3, 64'h22);
    step(1, 1, 0, 4'h6, 4'h3, 4'h3, 4'hF, 0, 4'hF, 0);
    // same-cycle bypass vs old contents
    step(1, 1, 0, 4'h6, 4'h1, 4'h2, 4'h1, 64'hABCD, 4'hF, 0);
    // no-operand icodes, and a write to RNONE
    step(1, 1, 0, 4'h3, 4'h5, 4'h6, 4'hF, 64'hDEAD, 4'hF, 0);
    step(1, 1, 0, 4'h0, 4'h7, 4'h8, 4'hF, 0, 4'hF, 0);
    step(1, 1, 0, 4'h6, 4'h3, 4'h1, 4'hF, 0, 4'hF, 0);
    // stall for three cycles while a write lands in r0
    step(1, 1, 1, 4'h6, 4'h2, 4'h2, 4'hF, 0, 4'h0, 64'h5);
    step(1, 0, 1, 4'hA, 4'h0, 4'h0, 4'hF, 0, 4'h0, 64'h5);
    step(1, 1, 1, 4'h9, 4'h1, 4'h0, 4'hF, 0, 4'h0, 64'h5);
    step(1, 1, 0, 4'h2, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);
    // undefined icodes C..F
    step(1, 1, 0, 4'hC, 4'h1, 4'h1, 4'hF, 0, 4'hF, 0);
    step(1, 1, 0, 4'hF, 4'h1, 4'h1, 4'hF, 0, 4'hF, 0);

    for (int n = 0; n < 300; n++)
      step(1, ($urandom % 5) != 0, ($urandom % 5) == 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), {$urandom, $urandom},
           4'($urandom_range(0, 15)), {$urandom, $urandom});

    // mid-stream reset while out_valid is high
    step(1, 1, 0, 4'h9, 4'h0, 4'h0, 4'h0, 64'h77, 4'hF, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 64'(ov1), 64'h0);
    chk("midreset.valA", va1, 64'h0);
    chk("midreset.valB", vb1, 64'h0);
    mdl_reset();
    step(0, 1, 0, 4'h6, 4'h0, 4'h0, 4'hF, 0, 4'h0, 64'h99);
    step(0, 1, 0, 4'h6, 4'h0, 4'h0, 4'h0, 64'h98, 4'hF, 0);
    step(1, 1, 0, 4'h6, 4'h0, 4'h4, 4'hF, 0, 4'hF, 0);
    step(1, 1, 0, 4'hB, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);
    step(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);

    @(posedge clk);
    #2 done = 1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
